// File: rtl/retire_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : retire_checker_pkg
//  Description : Shared types for the retirement checker: effect-kind
//                encoding, checker state enum and expected-trace entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package retire_checker_pkg;

    // Trace fields are stored at the core's datapath width.
    localparam int TRACE_XLEN = 32;

    // Expected architectural effect of one retired instruction.
    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_REG   = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]            kind;
        logic [TRACE_XLEN-1:0] pc;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] data;
        logic [TRACE_XLEN-1:0] addr;
    } trace_entry_t;

    // A REG expectation targeting x0 has no architectural effect.
    function automatic logic [1:0] effective_kind(input trace_entry_t e);
        if (e.kind == KIND_REG && e.rd == 5'd0) begin
            return KIND_NONE;
        end
        return e.kind;
    endfunction

endpackage : retire_checker_pkg
`default_nettype wire

// File: rtl/retire_trace_ram.sv
`default_nettype none
// ============================================================================
//  Module      : retire_trace_ram
//  Description : Expected-trace storage. One synchronous write port for
//                trace loading, one combinational read port indexed by the
//                checker so every retirement is compared in its own cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_ram
    import retire_checker_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  trace_entry_t       i_wr_entry,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output trace_entry_t       o_rd_entry
);

    // Contents are deliberately not reset so a trace survives a checker reset.
    trace_entry_t mem_q [DEPTH];

    // Trace load write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_wr_idx] <= i_wr_entry;
        end
    end

    assign o_rd_entry = mem_q[i_rd_idx];

endmodule : retire_trace_ram
`default_nettype wire

// File: rtl/retire_checker.sv
`default_nettype none
// ============================================================================
//  Module      : retire_checker
//  Description : Compares each retired instruction against a loaded
//                expected trace, in order. Counts passes/fails, captures the
//                first mismatching index and ends a run on a watchdog expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module retire_checker
    import retire_checker_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 64,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               reset,
    // trace load
    input  logic               exp_we,
    input  logic [IDX_W-1:0]   exp_idx,
    input  logic [1:0]         exp_kind,
    input  logic [XLEN-1:0]    exp_pc,
    input  logic [4:0]         exp_rd,
    input  logic [XLEN-1:0]    exp_data,
    input  logic [XLEN-1:0]    exp_addr,
    // run control
    input  logic               start,
    input  logic [IDX_W:0]     num_entries,
    // retirement tap
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_pc,
    input  logic               ret_rd_we,
    input  logic [4:0]         ret_rd,
    input  logic [XLEN-1:0]    ret_rd_data,
    input  logic               ret_mem_we,
    input  logic [XLEN-1:0]    ret_mem_addr,
    input  logic [XLEN-1:0]    ret_mem_wdata,
    // status
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [IDX_W:0]     pass_count,
    output logic [IDX_W:0]     fail_count,
    output logic               first_fail_valid,
    output logic [IDX_W-1:0]   first_fail_idx
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    num_q, num_d;
    logic [IDX_W:0]    pass_q, pass_d;
    logic [IDX_W:0]    fail_q, fail_d;
    logic              ffv_q, ffv_d;
    logic [IDX_W-1:0]  ffi_q, ffi_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    trace_entry_t      wr_entry;
    trace_entry_t      rd_entry;
    logic              trace_we;
    logic              rd_write;
    logic              entry_match;
    logic              last_entry;

    // The trace is frozen while a run is comparing against it.
    assign trace_we = exp_we && (state_q != ST_RUN);

    // Pack the load port fields into a trace entry.
    always_comb begin
        wr_entry      = '0;
        wr_entry.kind = exp_kind;
        wr_entry.pc   = exp_pc;
        wr_entry.rd   = exp_rd;
        wr_entry.data = exp_data;
        wr_entry.addr = exp_addr;
    end

    retire_trace_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_trace (
        .clk        (clk),
        .i_we       (trace_we),
        .i_wr_idx   (exp_idx),
        .i_wr_entry (wr_entry),
        .i_rd_idx   (idx_q),
        .o_rd_entry (rd_entry)
    );

    // A write to x0 is architecturally invisible, so it is not a register write.
    assign rd_write   = ret_rd_we && (ret_rd != 5'd0);
    assign last_entry = ({1'b0, idx_q} == (num_q - CNT_ONE));

    // Compare the current retirement against the expected entry at idx.
    always_comb begin
        entry_match = 1'b0;
        if (ret_pc == rd_entry.pc) begin
            case (effective_kind(rd_entry))
                KIND_NONE:  entry_match = !rd_write && !ret_mem_we;
                KIND_REG:   entry_match = rd_write && (ret_rd == rd_entry.rd) &&
                                          (ret_rd_data == rd_entry.data) && !ret_mem_we;
                KIND_STORE: entry_match = ret_mem_we && (ret_mem_addr == rd_entry.addr) &&
                                          (ret_mem_wdata == rd_entry.data) && !rd_write;
                default:    entry_match = 1'b0;
            endcase
        end
    end

    // Next-state logic: run control, counters, first-fail capture, watchdog.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        num_d     = num_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ffv_d     = ffv_q;
        ffi_d     = ffi_q;
        wd_d      = wd_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    idx_d     = '0;
                    num_d     = num_entries;
                    pass_d    = '0;
                    fail_d    = '0;
                    ffv_d     = 1'b0;
                    wd_d      = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_RUN: begin
                // A retirement on the expiry cycle wins over the watchdog.
                if (ret_valid) begin
                    wd_d  = '0;
                    idx_d = idx_q + 1'b1;
                    if (entry_match) begin
                        pass_d = pass_q + CNT_ONE;
                    end else begin
                        fail_d = fail_q + CNT_ONE;
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffi_d = idx_q;
                        end
                    end
                    if (last_entry) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Checker state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
            wd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffv_q     <= ffv_d;
            ffi_q     <= ffi_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign timeout          = timeout_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule : retire_checker
`default_nettype wire

// File: doc/retire_checker.md
# retire_checker

Self-checking retirement monitor for the single-cycle RV32I `cpu`. It replaces hand-written per-instruction checks with a loadable expected-trace memory and compares every retired instruction's PC, register write and store against that trace in order. It accumulates pass/fail counts, captures the first mismatch and detects hangs via a watchdog. It sits beside `cpu` in simulation and FPGA bring-up, fed from the core's retirement tap.

## Interface
Parameters:
- XLEN, 32, datapath width.
- DEPTH, 64, expected-trace entries (power of 2).
- IDX_W, $clog2(DEPTH), trace index width.
- TIMEOUT, 256, max cycles between retirements while running.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- exp_we  in  1  trace-load write strobe.
- exp_idx  in  IDX_W  trace-load address.
- exp_kind  in  2  expected effect: NONE=0, REG=1, STORE=2.
- exp_pc  in  XLEN  expected PC.
- exp_rd  in  5  expected destination register (REG).
- exp_data  in  XLEN  expected rd value (REG) or store data (STORE).
- exp_addr  in  XLEN  expected store byte address (STORE).
- start  in  1  one-cycle pulse that begins a check run.
- num_entries  in  IDX_W+1  entries to check, 1..DEPTH; sampled on start.
- ret_valid  in  1  one instruction retired this cycle.
- ret_pc, ret_rd_data, ret_mem_addr, ret_mem_wdata  in  XLEN  retirement tap.
- ret_rd_we, ret_mem_we  in  1  retirement write enables.
- ret_rd  in  5  retirement destination.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- timeout  out  1  run ended by watchdog; held until next start.
- pass_count, fail_count  out  IDX_W+1  checked-entry counters.
- first_fail_valid  out  1  at least one mismatch seen.
- first_fail_idx  out  IDX_W  index of first mismatch.

## Operation
- FSM: IDLE -> RUN on start. RUN -> DONE when the check of entry num_entries-1 completes, or when the watchdog expires (also sets timeout). DONE -> RUN on start. Any state -> IDLE on reset.
- On start: idx, pass_count, fail_count, first_fail_valid, timeout and watchdog are cleared; num_entries is latched.
- start while in RUN is ignored. exp_we is honoured only in IDLE or DONE; it is ignored in RUN.
- Per ret_valid in RUN, entry idx is compared. The entry matches when all of these hold:
  - PC matches.
  - REG: ret_rd_we=1, ret_rd=exp_rd, ret_rd_data=exp_data, ret_mem_we=0.
  - STORE: ret_mem_we=1, ret_mem_addr=exp_addr, ret_mem_wdata=exp_data, ret_rd_we=0.
  - NONE: neither enable is set.
- A retirement with ret_rd_we=1 and ret_rd=0 counts as no register write, because x0 is hardwired to zero. exp_kind=REG with exp_rd=0 is therefore treated as NONE.
- On a match, pass_count increments. On a mismatch, fail_count increments; if first_fail_valid=0, it sets first_fail_valid and captures idx. idx then increments.
- Watchdog: counts cycles in RUN, cleared on each ret_valid, and expires when it reaches TIMEOUT.
- ret_valid outside RUN is ignored.
- Reset does not clear trace contents. A reset mid-run aborts to IDLE with all outputs at reset values.

## Timing
- Reset values: busy=0, done=0, timeout=0, pass_count=0, fail_count=0, first_fail_valid=0, first_fail_idx=0.
- busy=1 from the cycle after start until the cycle DONE is entered.
- Trace read is combinational on idx, or a registered read with idx prefetched; retirements are checked at full rate, one per cycle, with no stalls.
- Counters and first_fail update on the clock edge that samples ret_valid and are visible the next cycle.
- done rises on the same edge as the final counter update. pass_count+fail_count = num_entries whenever done=1 and timeout=0.
- When ret_valid coincides with watchdog expiry, the retirement is checked first and the watchdog is cleared, so no timeout occurs.
- num_entries = DEPTH is legal. idx wraps only internally and is never reused in the same run.

## Structure
- Package retire_checker_pkg holds the kind encoding (KIND_NONE, KIND_REG, KIND_STORE), the state enum (ST_IDLE, ST_RUN, ST_DONE) and the trace-entry struct (kind, pc, rd, data, addr).
- Sub-module retire_trace_ram: DEPTH × entry-struct RAM with one write port (exp_*) and one read port (idx).
- The FSM, comparators, counters and watchdog live in retire_checker.

## Test plan
- Load 2 entries: {REG, pc 0x0, x1, 0xDEADBEEF} and {STORE, pc 0x4, addr 0x4, 0xDEADBEEF}. Drive matching retirements -> pass_count=2, fail_count=0, done=1.
- Load 3 REG entries (add x4=0x14, sub x5=0xA, and x6=0x5). Drive x5=0xB on the second retirement -> fail_count=1, pass_count=2, first_fail_idx=1.
- Expect entry {NONE, pc 0x0}. Retire addi x0,x0,-1 (rd_we=1, rd=0, data=0xFFFFFFFF) -> counted as pass.
- Branch skip: expect PCs 0x1C then 0x24. Retire PCs 0x1C then 0x20 -> fail_count=1 at idx 1.
- num_entries=4, only 2 retirements, then ret_valid low for TIMEOUT cycles -> timeout=1, done=1, pass_count=2.
- Assert reset mid-run after 1 retirement -> all outputs 0 next cycle. Then start again -> trace contents intact and the run passes.
